// File: rtl/branch_predictor_bht_pkg.sv
// ----------------------------------------------------------------------------
// branch_predictor_bht_pkg
//
// Shared constants for the ID-stage branch predictor: MIPS opcode and REGIMM
// rt encodings for the conditional branches, the counter reset value and a
// decode helper.
//
// No ports (package).
// ----------------------------------------------------------------------------
package branch_predictor_bht_pkg;

    // Primary opcode field instr[31:26].
    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00,
        OP_REGIMM  = 6'h01,
        OP_J       = 6'h02,
        OP_JAL     = 6'h03,
        OP_BEQ     = 6'h04,
        OP_BNE     = 6'h05,
        OP_BLEZ    = 6'h06,
        OP_BGTZ    = 6'h07
    } opcode_e;

    // rt field instr[20:16] of REGIMM instructions that are conditional branches.
    typedef enum logic [4:0] {
        RT_BLTZ   = 5'h00,
        RT_BGEZ   = 5'h01,
        RT_BLTZAL = 5'h10,
        RT_BGEZAL = 5'h11
    } regimm_rt_e;

    // Counter reset value: weakly not-taken for a 2-bit counter.
    localparam int BHT_INIT_CNT = 1;

    // Conditional-branch decode from the opcode and rt fields only.
    // Jumps (J/JAL) and REGIMM traps/other rt values are not branches.
    function automatic logic is_cond_branch(input logic [5:0] opcode,
                                            input logic [4:0] rt);
        logic br;
        br = 1'b0;
        case (opcode)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: br = 1'b1;
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL: br = 1'b1;
                    default:                                br = 1'b0;
                endcase
            end
            default: br = 1'b0;
        endcase
        return br;
    endfunction

endpackage

// File: rtl/bht_pht.sv
// ----------------------------------------------------------------------------
// bht_pht
//
// Pattern history table: 2^INDEX_W saturating counters of CNT_W bits.
//
// Ports:
//   clk         in  clock, all writes on the rising edge
//   rst         in  synchronous active-high reset, loads INIT_CNT everywhere
//   rd_idx_i    in  read index (combinational read port)
//   rd_cnt_o    out counter at rd_idx_i, pre-update value on a collision
//   wr_en_i     in  train the entry at wr_idx_i this cycle
//   wr_idx_i    in  training index
//   wr_taken_i  in  1: increment (saturate at max), 0: decrement (saturate at 0)
//
// The per-entry reset and combinational read keep this in registers rather
// than block RAM; reset has priority over a simultaneous write.
// ----------------------------------------------------------------------------
module bht_pht #(
    parameter int INDEX_W  = 10,
    parameter int CNT_W    = 2,
    parameter int INIT_CNT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic [CNT_W-1:0]   rd_cnt_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_idx_i,
    input  logic               wr_taken_i
);

    localparam int DEPTH = 1 << INDEX_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CNT);

    logic [CNT_W-1:0] pht_q [DEPTH];
    logic [CNT_W-1:0] wr_cur;
    logic [CNT_W-1:0] wr_cnt_d;

    // No bypass: a read of the entry being written sees the old value.
    assign rd_cnt_o = pht_q[rd_idx_i];
    assign wr_cur   = pht_q[wr_idx_i];

    always_comb begin
        wr_cnt_d = wr_cur;
        if (wr_taken_i) begin
            if (wr_cur != CNT_MAX) wr_cnt_d = wr_cur + 1'b1;
        end else begin
            if (wr_cur != '0) wr_cnt_d = wr_cur - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht_q[i] <= CNT_INIT;
            end
        end else if (wr_en_i) begin
            pht_q[wr_idx_i] <= wr_cnt_d;
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// ----------------------------------------------------------------------------
// branch_predictor_bht
//
// ID-stage dynamic predictor for conditional branches. Predicts from a table
// of saturating counters indexed by PC, trains when the branch resolves in
// EX and flags the misprediction there.
//
// Compile-time option: BHT_GSHARE_EN -- XOR a non-speculative global history
// register (resolution order) into the table index. Undefined: bimodal index,
// no history register, GHR_W unused.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   pcD, instrD    instruction in ID
//   is_branchD     instrD is a conditional branch
//   pred_takeD     predicted taken (combinational)
//   pred_idxD      table index used, carried down the pipe to EX
//   update_enE     a conditional branch resolved in EX this cycle
//   update_idxE    carried pred_idxD
//   pred_takeE     carried pred_takeD
//   actual_takeE   resolved outcome
//   mispredictE    update_enE & (actual_takeE != pred_takeE)
//   branch_cnt     resolved-branch count (wraps)
//   mispred_cnt    misprediction count (wraps)
// ----------------------------------------------------------------------------
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int INDEX_W  = 10,
    parameter int CNT_W    = 2,
    parameter int INIT_CNT = BHT_INIT_CNT,
    parameter int GHR_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pcD,
    input  logic [31:0]        instrD,
    output logic               is_branchD,
    output logic               pred_takeD,
    output logic [INDEX_W-1:0] pred_idxD,
    input  logic               update_enE,
    input  logic [INDEX_W-1:0] update_idxE,
    input  logic               pred_takeE,
    input  logic               actual_takeE,
    output logic               mispredictE,
    output logic [31:0]        branch_cnt,
    output logic [31:0]        mispred_cnt
);

    logic [INDEX_W-1:0] pc_idx;
    logic [INDEX_W-1:0] rd_idx;
    logic [CNT_W-1:0]   rd_cnt;
    logic [31:0]        branch_cnt_q, branch_cnt_d;
    logic [31:0]        mispred_cnt_q, mispred_cnt_d;

    // Word-aligned PC: drop the byte offset.
    assign pc_idx = pcD[INDEX_W+1:2];

`ifdef BHT_GSHARE_EN
    logic [GHR_W-1:0] ghr_q, ghr_d;

    assign rd_idx = pc_idx ^ INDEX_W'(ghr_q);

    // Shift in the resolved outcome; the cast drops the oldest bit.
    always_comb begin
        ghr_d = ghr_q;
        if (update_enE) ghr_d = GHR_W'({ghr_q, actual_takeE});
    end

    always_ff @(posedge clk) begin
        if (rst) ghr_q <= '0;
        else     ghr_q <= ghr_d;
    end
`else
    assign rd_idx = pc_idx;
`endif

    assign is_branchD  = is_cond_branch(instrD[31:26], instrD[20:16]);
    assign pred_idxD   = rd_idx;
    assign pred_takeD  = is_branchD & rd_cnt[CNT_W-1];
    assign mispredictE = update_enE & (actual_takeE != pred_takeE);

    bht_pht #(
        .INDEX_W  (INDEX_W),
        .CNT_W    (CNT_W),
        .INIT_CNT (INIT_CNT)
    ) u_pht (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (rd_idx),
        .rd_cnt_o   (rd_cnt),
        .wr_en_i    (update_enE),
        .wr_idx_i   (update_idxE),
        .wr_taken_i (actual_takeE)
    );

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (update_enE)  branch_cnt_d  = branch_cnt_q + 32'd1;
        if (mispredictE) mispred_cnt_d = mispred_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

    // Fields the predictor does not look at; GHR_W only matters with gshare.
    logic unused_ok;
    assign unused_ok = ^{pcD[31:INDEX_W+2], pcD[1:0], instrD[25:21],
                         instrD[15:0], (GHR_W > INDEX_W)};

endmodule

// File: tb/tb_branch_predictor_bht.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor_bht
//
// Directed bench for branch_predictor_bht (INDEX_W=10, CNT_W=2). Expected
// values are queued while a step is driven and compared mid-cycle.
// ----------------------------------------------------------------------------
module tb_branch_predictor_bht;

    localparam int INDEX_W = 10;

    // Instruction encodings
    localparam logic [31:0] I_BEQ    = 32'h1022_0004;
    localparam logic [31:0] I_BNE    = 32'h1422_0004;
    localparam logic [31:0] I_BLEZ   = 32'h1820_0004;
    localparam logic [31:0] I_BGTZ   = 32'h1c20_0004;
    localparam logic [31:0] I_BGEZAL = 32'h0431_0004;
    localparam logic [31:0] I_RI_RT2 = 32'h0422_0004;
    localparam logic [31:0] I_ADDU   = 32'h0022_1821;
    localparam logic [31:0] I_J      = 32'h0800_0040;

    localparam logic [31:0] PC_A = 32'h8000_0100; // idx 0x040
    localparam logic [31:0] PC_B = 32'h8000_0104; // idx 0x041

    localparam int S_BR = 0, S_PT = 1, S_IDX = 2, S_MP = 3, S_BC = 4, S_MC = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        pcD, instrD;
    logic               is_branchD, pred_takeD;
    logic [INDEX_W-1:0] pred_idxD;
    logic               update_enE, pred_takeE, actual_takeE;
    logic [INDEX_W-1:0] update_idxE;
    logic               mispredictE;
    logic [31:0]        branch_cnt, mispred_cnt;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;

    always #5 clk = ~clk;

    branch_predictor_bht #(
        .INDEX_W  (INDEX_W),
        .CNT_W    (2),
        .INIT_CNT (1),
        .GHR_W    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pcD          (pcD),
        .instrD       (instrD),
        .is_branchD   (is_branchD),
        .pred_takeD   (pred_takeD),
        .pred_idxD    (pred_idxD),
        .update_enE   (update_enE),
        .update_idxE  (update_idxE),
        .pred_takeE   (pred_takeE),
        .actual_takeE (actual_takeE),
        .mispredictE  (mispredictE),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_BR:    return {31'd0, is_branchD};
            S_PT:    return {31'd0, pred_takeD};
            S_IDX:   return {22'd0, pred_idxD};
            S_MP:    return {31'd0, mispredictE};
            S_BC:    return branch_cnt;
            S_MC:    return mispred_cnt;
            default: return 32'hdead_beef;
        endcase
    endfunction

    // Apply one cycle of stimulus just after the rising edge.
    task automatic drive(input logic r, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ue, input logic [INDEX_W-1:0] ui,
                         input logic pe, input logic ae);
        @(posedge clk);
        #1;
        rst          = r;
        pcD          = pc;
        instrD       = ins;
        update_enE   = ue;
        update_idxE  = ui;
        pred_takeE   = pe;
        actual_takeE = ae;
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
        sb_q.push_back('{tag, sel, v});
    endtask

    // Mid-cycle: drain the scoreboard against the settled outputs.
    task automatic check_now();
        exp_t        e;
        logic [31:0] o;
        #4;
        txn++;
        $display("txn %0d rst=%b pc=%h instr=%h upd=%b idx=%h pe=%b ae=%b checks_queued=%0d",
                 txn, rst, pcD, instrD, update_enE, update_idxE, pred_takeE,
                 actual_takeE, sb_q.size());
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = observe(e.sel);
            checks++;
            assert (o === e.exp) else begin
                failures++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, o, e.exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; pcD = '0; instrD = '0; update_enE = 1'b0;
        update_idxE = '0; pred_takeE = 1'b0; actual_takeE = 1'b0;
        repeat (2) @(posedge clk);

`ifdef BHT_GSHARE_EN
        // Two taken updates: ghr 0 -> 1 -> 3.
        drive(0, PC_A, I_BEQ, 1, 10'h040, 0, 1);
        expect_val("gs_mp0", S_MP, 32'd1);
        check_now();
        drive(0, PC_A, I_BEQ, 1, 10'h040, 1, 1);
        expect_val("gs_mp1", S_MP, 32'd0);
        check_now();
        drive(0, PC_A, I_BEQ, 0, 10'h000, 0, 0);
        expect_val("gs_idx", S_IDX, 32'h043);
        expect_val("gs_br",  S_BR,  32'd1);
        expect_val("gs_pt",  S_PT,  32'd0);
        expect_val("gs_bc",  S_BC,  32'd2);
        expect_val("gs_mc",  S_MC,  32'd1);
        check_now();
`else
        // Reset state
        drive(0, PC_A, I_BEQ, 0, 10'h000, 0, 0);
        expect_val("rst_br",  S_BR,  32'd1);
        expect_val("rst_idx", S_IDX, 32'h040);
        expect_val("rst_pt",  S_PT,  32'd0);
        expect_val("rst_mp",  S_MP,  32'd0);
        expect_val("rst_bc",  S_BC,  32'd0);
        expect_val("rst_mc",  S_MC,  32'd0);
        check_now();

        // Collision: counter 1 -> 2 while ID reads the same entry
        drive(0, PC_A, I_BEQ, 1, 10'h040, 0, 1);
        expect_val("col_pt_same", S_PT, 32'd0);
        expect_val("col_mp",      S_MP, 32'd1);
        check_now();
        drive(0, PC_A, I_BEQ, 0, 10'h000, 0, 0);
        expect_val("col_pt_next", S_PT, 32'd1);
        expect_val("col_bc",      S_BC, 32'd1);
        expect_val("col_mc",      S_MC, 32'd1);
        check_now();

        // 2 -> 3, then saturate at 3
        drive(0, PC_A, I_BEQ, 1, 10'h040, 1, 1);
        expect_val("tr3_mp", S_MP, 32'd0);
        check_now();
        drive(0, PC_A, I_BEQ, 1, 10'h040, 1, 1);
        expect_val("sat_pt", S_PT, 32'd1);
        expect_val("sat_bc", S_BC, 32'd2);
        check_now();

        // Not-taken: 3 -> 2 (still taken) -> 1 -> 0 -> 0 (floor), then 0 -> 1
        drive(0, PC_A, I_BEQ, 1, 10'h040, 1, 0);
        expect_val("nt1_mp", S_MP, 32'd1);
        expect_val("nt1_bc", S_BC, 32'd3);
        expect_val("nt1_mc", S_MC, 32'd1);
        check_now();
        drive(0, PC_A, I_BEQ, 1, 10'h040, 1, 0);
        expect_val("nt2_pt", S_PT, 32'd1);
        expect_val("nt2_mc", S_MC, 32'd2);
        check_now();
        drive(0, PC_A, I_BEQ, 1, 10'h040, 0, 0);
        expect_val("nt3_pt", S_PT, 32'd0);
        expect_val("nt3_mp", S_MP, 32'd0);
        check_now();
        drive(0, PC_A, I_BEQ, 1, 10'h040, 0, 0);
        check_now();
        drive(0, PC_A, I_BEQ, 1, 10'h040, 0, 1);
        expect_val("floor_mp", S_MP, 32'd1);
        check_now();
        drive(0, PC_A, I_BEQ, 0, 10'h000, 0, 0);
        expect_val("floor_pt", S_PT, 32'd0);
        expect_val("floor_bc", S_BC, 32'd8);
        expect_val("floor_mc", S_MC, 32'd4);
        check_now();

        // Train idx 0x041 to 3 (two taken updates)
        drive(0, PC_B, I_BNE, 1, 10'h041, 1, 1);
        check_now();
        drive(0, PC_B, I_BNE, 1, 10'h041, 1, 1);
        check_now();

        // Decode at a trained index
        drive(0, PC_B, I_ADDU, 0, 10'h000, 0, 1);
        expect_val("addu_br",  S_BR,  32'd0);
        expect_val("addu_pt",  S_PT,  32'd0);
        expect_val("addu_idx", S_IDX, 32'h041);
        expect_val("noupd_mp", S_MP,  32'd0);
        check_now();
        drive(0, PC_B, I_BNE, 0, 10'h000, 0, 0);
        expect_val("bne_br", S_BR, 32'd1);
        expect_val("bne_pt", S_PT, 32'd1);
        expect_val("bne_bc", S_BC, 32'd10);
        expect_val("bne_mc", S_MC, 32'd4);
        check_now();
        drive(0, PC_B, I_RI_RT2, 0, 10'h000, 0, 0);
        expect_val("ri2_br", S_BR, 32'd0);
        expect_val("ri2_pt", S_PT, 32'd0);
        check_now();
        drive(0, PC_B, I_BGEZAL, 0, 10'h000, 0, 0);
        expect_val("bgezal_br", S_BR, 32'd1);
        expect_val("bgezal_pt", S_PT, 32'd1);
        check_now();
        drive(0, PC_B, I_J, 0, 10'h000, 0, 0);
        expect_val("j_br", S_BR, 32'd0);
        check_now();
        drive(0, PC_A, I_BLEZ, 0, 10'h000, 0, 0);
        expect_val("blez_br", S_BR, 32'd1);
        expect_val("blez_pt", S_PT, 32'd0);
        check_now();
        drive(0, PC_B, I_BGTZ, 0, 10'h000, 0, 0);
        expect_val("bgtz_br", S_BR, 32'd1);
        expect_val("bgtz_pt", S_PT, 32'd1);
        check_now();

        // Reset priority over a simultaneous taken update on the trained entry
        drive(1, PC_B, I_BEQ, 1, 10'h041, 0, 1);
        check_now();
        drive(0, PC_B, I_BEQ, 0, 10'h000, 0, 0);
        expect_val("rp_pt", S_PT, 32'd0);
        expect_val("rp_bc", S_BC, 32'd0);
        expect_val("rp_mc", S_MC, 32'd0);
        check_now();
        // Counter restarted at 1: one taken update makes it predict taken
        drive(0, PC_B, I_BEQ, 1, 10'h041, 0, 1);
        expect_val("rp_tr_pt", S_PT, 32'd0);
        check_now();
        drive(0, PC_B, I_BEQ, 0, 10'h000, 0, 0);
        expect_val("rp_tr_pt2", S_PT, 32'd1);
        expect_val("rp_tr_bc",  S_BC, 32'd1);
        check_now();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
